uart_word_tx: RTL and testbench

- UART transmitter; the send-side counterpart of the wrapper's UART receive path.
- Accepts a 32-bit word from the core or GPIO logic over a valid/ready handshake.
- Sends the word as WORD_BYTES consecutive 8N1 frames, least-significant byte first, each byte LSB-first.
- Used to stream instruction/memory readback and GPIO status to the host at the same line rate the receiver uses.

---
 rtl/uart_word_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_word_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_tx
// Purpose  : UART transmitter for 32-bit words. A word accepted over a
//            valid/ready handshake is sent as WORD_BYTES consecutive serial
//            frames: least-significant byte first, each byte LSB-first,
//            followed by STOP_BITS stop bits. There is no idle gap between
//            the bytes of one word.
//
// Ports    : clk          - system clock, all logic on the rising edge
//            rst          - synchronous active-high reset
//            uart_tx_en   - transmit enable, gates acceptance of new words
//            tx_word[31:0]- word to send; bytes at or above WORD_BYTES ignored
//            tx_valid     - tx_word is valid
//            tx_ready     - a word can be accepted this cycle
//            uart_txd     - serial line, idle high, driven from a flop
//            uart_tx_busy - a word is in flight (FSM not idle)
//            word_done    - one-cycle pulse in the first idle cycle after
//                           the final stop bit of a word
//
// Options  : `define UART_WORD_TX_PARITY_EN inserts an even-parity bit after
//            the data bits of every frame (8E1 instead of 8N1).
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BIT_RATE   = 9600,
  parameter int WORD_BYTES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_tx_en,
  input  logic [31:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        uart_txd,
  output logic        uart_tx_busy,
  output logic        word_done
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int TMR_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CYCLES_PER_BIT - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(WORD_BYTES - 1);
  // The stop counter only needs to distinguish the first and second stop bit.
  localparam logic             STOP_LAST = (STOP_BITS > 1) ? 1'b1 : 1'b0;

  // --------------------------------------------------------------------------
  // FSM encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_WORD_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       state_q,     state_d;
  logic [TMR_W-1:0] bit_tmr_q,   bit_tmr_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [1:0]       byte_idx_q,  byte_idx_d;
  logic             stop_cnt_q,  stop_cnt_d;
  logic [7:0]       shreg_q,     shreg_d;
  // Bytes of the accepted word still waiting to be sent, next byte in [7:0].
  logic [23:0]      word_rest_q, word_rest_d;
  logic             txd_q,       txd_d;
  logic             word_done_q, word_done_d;

  logic bit_end;
  logic xfer;

  assign tx_ready     = (state_q == ST_IDLE) && uart_tx_en && !rst;
  assign xfer         = tx_valid && tx_ready;
  assign bit_end      = (bit_tmr_q == TMR_LAST);
  assign uart_txd     = txd_q;
  assign uart_tx_busy = (state_q != ST_IDLE);
  assign word_done    = word_done_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    stop_cnt_d  = stop_cnt_q;
    shreg_d     = shreg_q;
    word_rest_d = word_rest_q;
    word_done_d = 1'b0;

    // The bit timer free-runs in every non-idle state and wraps at the end
    // of each bit period; state changes happen only on the wrap cycle, so
    // every state entry starts with a fresh count of zero.
    if (state_q == ST_IDLE) begin
      bit_tmr_d = '0;
    end else if (bit_end) begin
      bit_tmr_d = '0;
    end else begin
      bit_tmr_d = bit_tmr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d     = ST_START;
          byte_idx_d  = 2'd0;
          shreg_d     = tx_word[7:0];
          word_rest_d = tx_word[31:8];
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
            state_d    = ST_PARITY;
`else
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_WORD_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = 1'b1;
          end else if (byte_idx_q != LAST_BYTE) begin
            // Back-to-back frame: next byte goes straight to its start bit.
            state_d     = ST_START;
            byte_idx_d  = byte_idx_q + 2'd1;
            shreg_d     = word_rest_q[7:0];
            word_rest_d = {8'h00, word_rest_q[23:8]};
          end else begin
            state_d     = ST_IDLE;
            word_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Line driver. The line level is derived from the current state and
  // registered, so the wire lags the FSM by exactly one cycle and can never
  // glitch on a combinational path.
  // --------------------------------------------------------------------------
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_q[bit_idx_q];
`ifdef UART_WORD_TX_PARITY_EN
      ST_PARITY: txd_d = ^shreg_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_tmr_q   <= '0;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      stop_cnt_q  <= 1'b0;
      shreg_q     <= 8'h00;
      word_rest_q <= 24'h000000;
      txd_q       <= 1'b1;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_tmr_q   <= bit_tmr_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      shreg_q     <= shreg_d;
      word_rest_q <= word_rest_d;
      txd_q       <= txd_d;
      word_done_q <= word_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_tx
// Purpose  : Directed self-checking bench for uart_word_tx at 10 clocks per
//            bit. Frames are decoded from the serial line at mid-bit and
//            compared against hand-derived bytes. Honours
//            UART_WORD_TX_PARITY_EN (11-bit frames with even parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx;

  localparam int CPB = 10;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WORD_CYC = 4 * FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_tx_en = 1'b0;
  logic [31:0] tx_word = 32'h0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        uart_txd;
  logic        uart_tx_busy;
  logic        word_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  uart_word_tx #(
    .CLK_HZ    (1000),
    .BIT_RATE  (100),
    .WORD_BYTES(4),
    .STOP_BITS (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_tx_en  (uart_tx_en),
    .tx_word     (tx_word),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .uart_txd    (uart_txd),
    .uart_tx_busy(uart_tx_busy),
    .word_done   (word_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rel(input int t0, input int rel);
    while (cyc < t0 + rel) tick();
  endtask

  // Sends one word and decodes it from the line. The transfer edge is the
  // first tick; t0 is the cycle count just after it.
  task automatic send_word(input logic [31:0] w, input bit keep_valid, input bit drop_en);
    int         t0;
    int         d0;
    int         ready_bad;
    logic [7:0] got;
    logic [7:0] exp_b;
    tx_word  = w;
    tx_valid = 1'b1;
    tick();
    t0 = cyc;
    d0 = done_cnt;
    ready_bad = 0;
    check("xfer_busy", uart_tx_busy, 1);
    check("xfer_txd_latency", uart_txd, 1);
    check("xfer_ready_low", tx_ready, 0);
    if (!keep_valid) tx_valid = 1'b0;
    tx_word = w ^ 32'hdeadbeef;
    if (drop_en) uart_tx_en = 1'b0;
    wait_rel(t0, 1);
    check("start_fall", uart_txd, 0);
    for (int b = 0; b < 4; b++) begin
      exp_b = w[8*b +: 8];
      got   = 8'h00;
      for (int k = 0; k < FRAME_BITS; k++) begin
        wait_rel(t0, 1 + CPB * (FRAME_BITS * b + k) + CPB / 2);
        if (tx_ready !== 1'b0) ready_bad++;
        if (k == 0) check("start_bit", uart_txd, 0);
        else if (k <= 8) got[k-1] = uart_txd;
`ifdef UART_WORD_TX_PARITY_EN
        else if (k == 9) check("parity_bit", uart_txd, {31'b0, ^exp_b});
`endif
        else check("stop_bit", uart_txd, 1);
      end
      check("byte", {24'h0, got}, {24'h0, exp_b});
    end
    check("ready_low_in_word", ready_bad, 0);
    wait_rel(t0, WORD_CYC - 1);
    check("done_not_yet", word_done, 0);
    check("busy_last_cycle", uart_tx_busy, 1);
    check("no_early_done", done_cnt, d0);
    wait_rel(t0, WORD_CYC);
    check("word_done_pulse", word_done, 1);
    check("idle_after_word", uart_tx_busy, 0);
    check("stop_still_high", uart_txd, 1);
    check("ready_at_done", tx_ready, drop_en ? 32'd0 : 32'd1);
  endtask

  initial begin
    int bad;
    int t0;
    int d0;

    // Reset and idle
    rst = 1'b1;
    uart_tx_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_txd", uart_txd, 1);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", uart_tx_busy, 0);
    check("rst_done", word_done, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (uart_txd !== 1'b1 || tx_ready !== 1'b1 || uart_tx_busy !== 1'b0 || word_done !== 1'b0)
        bad++;
    end
    check("idle_100", bad, 0);

    // Single word: bytes 13 01 01 fd
    send_word(32'hfd010113, 1'b0, 1'b0);
    tick();
    check("done_single_cycle", word_done, 0);

    // Back-to-back words, second transfer coincides with word_done
    send_word(32'h00100793, 1'b0, 1'b0);
    send_word(32'hfddff06f, 1'b0, 1'b0);

    // Enable gating
    tick();
    uart_tx_en = 1'b0;
    tx_valid   = 1'b1;
    tx_word    = 32'h12345678;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1 || tx_ready !== 1'b0) bad++;
    end
    check("en_gating", bad, 0);
    uart_tx_en = 1'b1;

    // Enable dropped mid-word with tx_valid held: word completes, no second
    send_word(32'ha5c3_0f81, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) bad++;
    end
    check("no_second_word", bad, 0);
    tx_valid   = 1'b0;
    uart_tx_en = 1'b1;
    tick();

    // Reset during data bit 3 of byte 1 (byte 1 = 0xf0, bit 3 = 0)
    tx_word  = 32'h0000f00f;
    tx_valid = 1'b1;
    tick();
    t0 = cyc;
    d0 = done_cnt;
    tx_valid = 1'b0;
    wait_rel(t0, 1 + CPB * (FRAME_BITS + 4) + CPB / 2);
    check("mid_frame_bit3", uart_txd, 0);
    rst = 1'b1;
    tick();
    check("midrst_txd", uart_txd, 1);
    check("midrst_busy", uart_tx_busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    check("midrst_no_done", done_cnt, d0);

    // Recovery word; also covers parity bytes 13 01 fd 00
    send_word(32'h00fd0113, 1'b0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
